mem_access_stage: RTL and testbench

Memory-access/writeback stage directly downstream of the data-movement execute unit. Consumes that unit's result word, 2-bit `read`/`write` source/destination codes and memory address, runs a single-outstanding word transaction on the data bus for LDW/STW, and produces one register-file write pulse for LDW and MV. Holds off upstream with a ready signal while a bus transaction is in flight, and reports misalignment and bus-timeout faults.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/mem_access_stage_if.sv | 40 ++++
 rtl/bus_timeout.sv | 26 ++
 rtl/mem_access_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the memory-access/writeback stage: source/destination
// codes, decoded opcodes, fault codes and FSM states.
package cpu_pkg;

    // read/write source-destination codes from the execute unit
    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_MEM  = 2'b01;
    localparam logic [1:0] RW_REG  = 2'b10;

    // fault_code values
    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_LDW = 2'd1,
        OP_STW = 2'd2,
        OP_MV  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Map a read/write code pair to an operation; anything unrecognised is a no-op.
    function automatic op_e decode_op(input logic [1:0] i_read, input logic [1:0] i_write);
        if (i_read == RW_NONE || i_write == RW_NONE) return OP_NOP;
        if (i_read == RW_MEM && i_write == RW_REG)   return OP_LDW;
        if (i_read == RW_REG && i_write == RW_MEM)   return OP_STW;
        if (i_read == RW_REG && i_write == RW_REG)   return OP_MV;
        return OP_NOP;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Upstream op, data bus and writeback/fault signals of the memory-access stage.
interface mem_access_stage_if;

    // upstream op
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  read;
    logic [1:0]  write;
    logic [31:0] mem_addr;
    logic [31:0] y;
    logic [4:0]  rd;
    // data bus
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    // writeback and fault reporting
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [1:0]  fault_code;

    // stage side
    modport slave (
        input  in_valid, read, write, mem_addr, y, rd, bus_ack, bus_rdata,
        output in_ready, bus_req, bus_we, bus_addr, bus_wdata,
               wb_en, wb_rd, wb_data, fault, fault_code
    );

    // environment side (upstream unit, bus, register file)
    modport master (
        output in_valid, read, write, mem_addr, y, rd, bus_ack, bus_rdata,
        input  in_ready, bus_req, bus_we, bus_addr, bus_wdata,
               wb_en, wb_rd, wb_data, fault, fault_code
    );

endinterface

// File: rtl/bus_timeout.sv
// Cycle counter for an outstanding bus request. o_expired flags the cycle in
// which the count would reach TIMEOUT; it is qualified by i_en so a cycle
// carrying an ack (enable low) never reports expiry.
module bus_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    // count ack-less request cycles, cleared whenever no request is outstanding
    always_ff @(posedge clk) begin
        if (rst || i_clr) r_cnt <= 8'd0;
        else if (i_en)    r_cnt <= r_cnt + 8'd1;
    end

    assign o_expired = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access/writeback stage: single-outstanding word bus transaction for
// LDW/STW, one register write pulse for LDW/MV, misalignment and bus-timeout
// fault reporting. Every output comes straight from a register.
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_stage_if.slave  sif
);

    state_e      r_state, w_state_nxt;
    logic        r_in_ready, w_in_ready_nxt;
    logic        r_bus_req, w_bus_req_nxt;
    logic        r_bus_we, w_bus_we_nxt;
    logic [31:0] r_bus_addr, w_bus_addr_nxt;
    logic [31:0] r_bus_wdata, w_bus_wdata_nxt;
    logic        r_wb_en, w_wb_en_nxt;
    logic [4:0]  r_wb_rd, w_wb_rd_nxt;
    logic [31:0] r_wb_data, w_wb_data_nxt;
    logic        r_fault, w_fault_nxt;
    logic [1:0]  r_fault_code, w_fault_code_nxt;
    logic        r_is_ld, w_is_ld_nxt;
    logic [4:0]  r_rd, w_rd_nxt;

    op_e  w_op;
    logic w_accept;
    logic w_cnt_clr;
    logic w_cnt_en;
    logic w_expired;

    assign w_op      = decode_op(sif.read, sif.write);
    assign w_accept  = sif.in_valid && r_in_ready;
    assign w_cnt_clr = (r_state != ST_BUS);
    assign w_cnt_en  = (r_state == ST_BUS) && !sif.bus_ack;

    bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_cnt_clr),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // next state and next values of all registered outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_in_ready_nxt   = r_in_ready;
        w_bus_req_nxt    = r_bus_req;
        w_bus_we_nxt     = r_bus_we;
        w_bus_addr_nxt   = r_bus_addr;
        w_bus_wdata_nxt  = r_bus_wdata;
        w_wb_en_nxt      = 1'b0;
        w_wb_rd_nxt      = r_wb_rd;
        w_wb_data_nxt    = r_wb_data;
        w_fault_nxt      = 1'b0;
        w_fault_code_nxt = r_fault_code;
        w_is_ld_nxt      = r_is_ld;
        w_rd_nxt         = r_rd;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_rd_nxt = sif.rd;
                    case (w_op)
                        OP_MV: begin
                            w_wb_en_nxt   = 1'b1;
                            w_wb_rd_nxt   = sif.rd;
                            w_wb_data_nxt = sif.y;
                        end
                        OP_LDW, OP_STW: begin
                            if (sif.mem_addr[1:0] != 2'b00) begin
                                // misaligned: report and drop the op without touching the bus
                                w_fault_nxt      = 1'b1;
                                w_fault_code_nxt = FC_MISALIGN;
                            end else begin
                                w_state_nxt    = ST_BUS;
                                w_in_ready_nxt = 1'b0;
                                w_bus_req_nxt  = 1'b1;
                                w_bus_we_nxt   = (w_op == OP_STW);
                                w_bus_addr_nxt = {sif.mem_addr[31:2], 2'b00};
                                w_is_ld_nxt    = (w_op == OP_LDW);
                                if (w_op == OP_STW) w_bus_wdata_nxt = sif.y;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_BUS: begin
                // ack takes priority over expiry in the same cycle
                if (sif.bus_ack) begin
                    w_bus_req_nxt = 1'b0;
                    if (r_is_ld) begin
                        w_state_nxt   = ST_WB;
                        w_wb_en_nxt   = 1'b1;
                        w_wb_rd_nxt   = r_rd;
                        w_wb_data_nxt = sif.bus_rdata;
                    end else begin
                        w_state_nxt    = ST_IDLE;
                        w_in_ready_nxt = 1'b1;
                    end
                end else if (w_expired) begin
                    w_state_nxt      = ST_IDLE;
                    w_in_ready_nxt   = 1'b1;
                    w_bus_req_nxt    = 1'b0;
                    w_fault_nxt      = 1'b1;
                    w_fault_code_nxt = FC_TIMEOUT;
                end
            end
            ST_WB: begin
                // wb_en is high this cycle; reopen for new ops next cycle
                w_state_nxt    = ST_IDLE;
                w_in_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_in_ready_nxt = 1'b1;
                w_bus_req_nxt  = 1'b0;
            end
        endcase
    end

    // output and op-context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready   <= 1'b1;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= 32'd0;
            r_bus_wdata  <= 32'd0;
            r_wb_en      <= 1'b0;
            r_wb_rd      <= 5'd0;
            r_wb_data    <= 32'd0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
            r_is_ld      <= 1'b0;
            r_rd         <= 5'd0;
        end else begin
            r_in_ready   <= w_in_ready_nxt;
            r_bus_req    <= w_bus_req_nxt;
            r_bus_we     <= w_bus_we_nxt;
            r_bus_addr   <= w_bus_addr_nxt;
            r_bus_wdata  <= w_bus_wdata_nxt;
            r_wb_en      <= w_wb_en_nxt;
            r_wb_rd      <= w_wb_rd_nxt;
            r_wb_data    <= w_wb_data_nxt;
            r_fault      <= w_fault_nxt;
            r_fault_code <= w_fault_code_nxt;
            r_is_ld      <= w_is_ld_nxt;
            r_rd         <= w_rd_nxt;
        end
    end

    assign sif.in_ready   = r_in_ready;
    assign sif.bus_req    = r_bus_req;
    assign sif.bus_we     = r_bus_we;
    assign sif.bus_addr   = r_bus_addr;
    assign sif.bus_wdata  = r_bus_wdata;
    assign sif.wb_en      = r_wb_en;
    assign sif.wb_rd      = r_wb_rd;
    assign sif.wb_data    = r_wb_data;
    assign sif.fault      = r_fault;
    assign sif.fault_code = r_fault_code;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a vector table of ops with expected outputs,
// a writeback/fault scoreboard, and hand-written multi-cycle corner cases.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_stage_if bif();

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .sif (bif)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    typedef struct {
        logic [1:0]  rc;
        logic [1:0]  wc;
        logic [31:0] addr;
        logic [31:0] y;
        logic [4:0]  rd;
        int          waits;     // wait cycles before ack; -1 = never ack
        logic [31:0] rdata;
        logic        exp_bus;
        logic        exp_we;
        logic        exp_wb;
        logic [31:0] exp_data;
        logic        exp_fault;
        logic [1:0]  exp_code;
    } vec_t;

    wb_t        wb_q[$];
    logic [1:0] fc_q[$];
    wb_t        mon_e;
    logic [1:0] mon_c;
    vec_t       vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100 && bif.in_ready !== 1'b1; i++) @(negedge clk);
        chk("ready_wait", 32'(bif.in_ready), 32'd1);
    endtask

    task automatic drive_op(input logic [1:0] rc, input logic [1:0] wc, input logic [31:0] addr,
                            input logic [31:0] y, input logic [4:0] rd);
        bif.in_valid = 1'b1;
        bif.read     = rc;
        bif.write    = wc;
        bif.mem_addr = addr;
        bif.y        = y;
        bif.rd       = rd;
    endtask

    // scoreboard: every wb_en / fault pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (bif.wb_en === 1'b1) begin
                if (wb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_wb_unexpected: got rd=%0d data=%h want no writeback", bif.wb_rd, bif.wb_data);
                end else begin
                    mon_e = wb_q.pop_front();
                    chk("sb_wb_rd", 32'(bif.wb_rd), 32'(mon_e.rd));
                    chk("sb_wb_data", bif.wb_data, mon_e.data);
                end
            end
            if (bif.fault === 1'b1) begin
                if (fc_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_fault_unexpected: got code=%0d want no fault", bif.fault_code);
                end else begin
                    mon_c = fc_q.pop_front();
                    chk("sb_fault_code", 32'(bif.fault_code), 32'(mon_c));
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        wb_t e;
        wait_ready();
        drive_op(v.rc, v.wc, v.addr, v.y, v.rd);
        if (v.exp_wb) begin
            e.rd = v.rd; e.data = v.exp_data;
            wb_q.push_back(e);
        end
        if (v.exp_fault) fc_q.push_back(v.exp_code);
        @(negedge clk);   // cycle N+1
        bif.in_valid = 1'b0;
        chk("req_n1", 32'(bif.bus_req), 32'(v.exp_bus));
        chk("ready_n1", 32'(bif.in_ready), 32'(!v.exp_bus));
        if (v.exp_bus) begin
            chk("bus_we", 32'(bif.bus_we), 32'(v.exp_we));
            chk("bus_addr", bif.bus_addr, v.addr);
            if (v.exp_we) chk("bus_wdata", bif.bus_wdata, v.y);
            if (v.waits >= 0) begin
                for (int i = 0; i < v.waits; i++) begin
                    @(negedge clk);
                    chk("req_hold", 32'(bif.bus_req), 32'd1);
                    chk("ready_low", 32'(bif.in_ready), 32'd0);
                end
                bif.bus_ack   = 1'b1;
                bif.bus_rdata = v.rdata;
                @(negedge clk);   // cycle M+1
                bif.bus_ack   = 1'b0;
                bif.bus_rdata = $urandom;
                chk("req_drop", 32'(bif.bus_req), 32'd0);
                chk("ready_m1", 32'(bif.in_ready), 32'(v.exp_we));
                chk("wb_m1", 32'(bif.wb_en), 32'(v.exp_wb));
                chk("fault_m1", 32'(bif.fault), 32'd0);
                if (!v.exp_we) begin
                    @(negedge clk);   // cycle M+2
                    chk("ready_m2", 32'(bif.in_ready), 32'd1);
                    chk("wb_m2", 32'(bif.wb_en), 32'd0);
                end
            end else begin
                repeat (TO - 1) @(negedge clk);   // cycle N+TO
                chk("req_last", 32'(bif.bus_req), 32'd1);
                @(negedge clk);                   // cycle N+TO+1
                chk("to_fault", 32'(bif.fault), 32'd1);
                chk("to_req", 32'(bif.bus_req), 32'd0);
                chk("to_ready", 32'(bif.in_ready), 32'd1);
                chk("to_wb", 32'(bif.wb_en), 32'd0);
            end
        end else begin
            chk("wb_n1", 32'(bif.wb_en), 32'(v.exp_wb));
            chk("fault_n1", 32'(bif.fault), 32'(v.exp_fault));
            if (v.exp_fault) chk("code_n1", 32'(bif.fault_code), 32'(v.exp_code));
            @(negedge clk);
            chk("req_n2", 32'(bif.bus_req), 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        wb_t e;
        //              rc     wc     addr          y             rd     waits rdata         bus  we   wb   data          flt  code
        vecs[0]  = '{2'b10, 2'b10, 32'h0,        32'hDEADBEEF, 5'd3,  0,  32'h0,        1'b0,1'b0,1'b1,32'hDEADBEEF,1'b0,2'b00};
        vecs[1]  = '{2'b01, 2'b10, 32'h100,      32'h0,        5'd5,  2,  32'h12345678, 1'b1,1'b0,1'b1,32'h12345678,1'b0,2'b00};
        vecs[2]  = '{2'b10, 2'b01, 32'h204,      32'hA5A5A5A5, 5'd0,  0,  32'h0,        1'b1,1'b1,1'b0,32'h0,       1'b0,2'b00};
        vecs[3]  = '{2'b01, 2'b10, 32'h102,      32'h0,        5'd4,  0,  32'h0,        1'b0,1'b0,1'b0,32'h0,       1'b1,2'b01};
        vecs[4]  = '{2'b10, 2'b01, 32'h301,      32'h1,        5'd0,  0,  32'h0,        1'b0,1'b0,1'b0,32'h0,       1'b1,2'b01};
        vecs[5]  = '{2'b00, 2'b00, 32'h3,        32'h9,        5'd6,  0,  32'h0,        1'b0,1'b0,1'b0,32'h0,       1'b0,2'b00};
        vecs[6]  = '{2'b10, 2'b10, 32'h0,        32'h1,        5'd0,  0,  32'h0,        1'b0,1'b0,1'b1,32'h1,       1'b0,2'b00};
        vecs[7]  = '{2'b01, 2'b10, 32'h8,        32'h0,        5'd31, 0,  32'hCAFEF00D, 1'b1,1'b0,1'b1,32'hCAFEF00D,1'b0,2'b00};
        vecs[8]  = '{2'b01, 2'b01, 32'h10,       32'h7,        5'd2,  0,  32'h0,        1'b0,1'b0,1'b0,32'h0,       1'b0,2'b00};
        vecs[9]  = '{2'b10, 2'b01, 32'h40,       32'h11,       5'd0, -1,  32'h0,        1'b1,1'b1,1'b0,32'h0,       1'b1,2'b10};
        vecs[10] = '{2'b10, 2'b01, 32'h44,       32'h22,       5'd0,  3,  32'h0,        1'b1,1'b1,1'b0,32'h0,       1'b0,2'b00};
        vecs[11] = '{2'b01, 2'b10, 32'hFFFFFFFC, 32'h0,        5'd7,  1,  32'h0,        1'b1,1'b0,1'b1,32'h0,       1'b0,2'b00};
        vecs[12] = '{2'b10, 2'b10, 32'h3,        32'h55,       5'd9,  0,  32'h0,        1'b0,1'b0,1'b1,32'h55,      1'b0,2'b00};

        bif.in_valid = 1'b0; bif.read = 2'b00; bif.write = 2'b00;
        bif.mem_addr = 32'h0; bif.y = 32'h0; bif.rd = 5'd0;
        bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;

        // reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bif.in_ready), 32'd1);
        chk("rst_req", 32'(bif.bus_req), 32'd0);
        chk("rst_we", 32'(bif.bus_we), 32'd0);
        chk("rst_addr", bif.bus_addr, 32'd0);
        chk("rst_wdata", bif.bus_wdata, 32'd0);
        chk("rst_wb_en", 32'(bif.wb_en), 32'd0);
        chk("rst_wb_rd", 32'(bif.wb_rd), 32'd0);
        chk("rst_wb_data", bif.wb_data, 32'd0);
        chk("rst_fault", 32'(bif.fault), 32'd0);
        chk("rst_code", 32'(bif.fault_code), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // last fault was the timeout; code holds through the later clean ops
        chk("code_held", 32'(bif.fault_code), 32'd2);

        // back-to-back MV: second op accepted the cycle the first writes back
        wait_ready();
        drive_op(2'b10, 2'b10, 32'h0, 32'h11112222, 5'd10);
        e.rd = 5'd10; e.data = 32'h11112222; wb_q.push_back(e);
        @(negedge clk);
        chk("b2b_ready", 32'(bif.in_ready), 32'd1);
        chk("b2b_wb1", 32'(bif.wb_en), 32'd1);
        drive_op(2'b10, 2'b10, 32'h0, 32'h33334444, 5'd11);
        e.rd = 5'd11; e.data = 32'h33334444; wb_q.push_back(e);
        @(negedge clk);
        bif.in_valid = 1'b0;
        chk("b2b_wb2", 32'(bif.wb_en), 32'd1);
        chk("b2b_data2", bif.wb_data, 32'h33334444);
        @(negedge clk);

        // stray ack while idle is ignored
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        chk("stray_req", 32'(bif.bus_req), 32'd0);
        chk("stray_ready", 32'(bif.in_ready), 32'd1);
        chk("stray_wb", 32'(bif.wb_en), 32'd0);
        chk("stray_fault", 32'(bif.fault), 32'd0);

        // reset in the middle of a load abandons it silently
        wait_ready();
        drive_op(2'b01, 2'b10, 32'h80, 32'h0, 5'd12);
        @(negedge clk);
        bif.in_valid = 1'b0;
        chk("mid_req", 32'(bif.bus_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", 32'(bif.bus_req), 32'd0);
        chk("mid_rst_ready", 32'(bif.in_ready), 32'd1);
        chk("mid_rst_wb", 32'(bif.wb_en), 32'd0);
        chk("mid_rst_fault", 32'(bif.fault), 32'd0);
        rst = 1'b0;
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        repeat (TO + 2) @(negedge clk);
        chk("post_rst_req", 32'(bif.bus_req), 32'd0);

        chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
        chk("fc_q_empty", 32'(fc_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
